sr_ff_bank: RTL

//  Parametrised bank of WIDTH edge-triggered storage bits with a run-time mode

---
 rtl/sr_ff_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH-channel clocked storage bank with run-time mode select.
// Each channel behaves as an SR, JK, D or T flip-flop, chosen by mode.
// The bank also has sticky per-channel illegal-SR flags and a saturating
// counter of the clock edges that carry at least one illegal SR channel.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   en           update enable (0 = every channel holds)
//   mode         00=SR, 01=JK, 10=D, 11=T (applies to all channels)
//   a            S / J / D / T input per channel
//   b            R / K input per channel (don't-care in D and T modes)
//   clr_err      clears err and illegal_cnt
//   q            stored state
//   qbar         ~q, derived from q only
//   err          sticky: channel saw S=R=1 in SR mode while en=1
//   illegal_cnt  saturating count of edges with >=1 illegal SR channel
module sr_ff_bank #(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       SR_POLICY = 0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] err_base;
  logic [WIDTH-1:0] err_next;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;

  // Per-channel next state; b is never read in D or T mode.
  always_comb begin
    q_next = q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (mode)
        MODE_SR: begin
          case ({a[i], b[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11: begin
              if (SR_POLICY == 1)      q_next[i] = 1'b1;
              else if (SR_POLICY == 2) q_next[i] = 1'b0;
              else                     q_next[i] = q[i];
            end
            default: q_next[i] = q[i];
          endcase
        end
        MODE_JK: begin
          case ({a[i], b[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11:   q_next[i] = ~q[i];
            default: q_next[i] = q[i];
          endcase
        end
        MODE_D:  q_next[i] = a[i];
        MODE_T:  q_next[i] = a[i] ? ~q[i] : q[i];
        default: q_next[i] = q[i];
      endcase
    end
  end

  // Error bookkeeping: a clear drops the old value first, then this edge's
  // illegal channels are recorded on top of it.
  always_comb begin
    illegal  = (en && (mode == MODE_SR)) ? (a & b) : '0;
    err_base = clr_err ? '0 : err;
    err_next = err_base | illegal;
    cnt_base = clr_err ? '0 : illegal_cnt;
    cnt_next = cnt_base;
    if ((|illegal) && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q           <= RESET_VAL;
      err         <= '0;
      illegal_cnt <= '0;
    end else begin
      if (en) begin
        q <= q_next;
      end
      err         <= err_next;
      illegal_cnt <= cnt_next;
    end
  end

  assign qbar = ~q;

endmodule
